// File: rtl/cr_kme_drng_pkg.sv
// Shared types and widths for the DRNG key assembler.
package cr_kme_drng_pkg;

  localparam int unsigned DRNG_WORD_W = 128;
  localparam int unsigned KEY_W       = 256;

  typedef enum logic [1:0] {
    FETCH_HI = 2'd0,
    FETCH_LO = 2'd1,
    HOLD     = 2'd2
  } state_e;

endpackage

// File: rtl/cr_kme_drng_rct.sv
// Repetition-count health test on accepted DRNG words (used under CR_KME_DRNG_HEALTH_EN).
module cr_kme_drng_rct
  import cr_kme_drng_pkg::*;
#(
  parameter int unsigned HT_CUTOFF = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   word_valid,
  input  logic [DRNG_WORD_W-1:0] word,
  output logic                   word_match,
  output logic                   health_fail
);

  localparam int unsigned RepW = $clog2(HT_CUTOFF) + 1;

  logic [DRNG_WORD_W-1:0] prev_q;
  logic                   have_prev_q;
  logic [RepW-1:0]        rep_cnt_q;
  logic [RepW-1:0]        rep_next;

  // The first word after reset has no predecessor, so it can never match.
  assign word_match = word_valid & have_prev_q & (word == prev_q);
  assign rep_next   = rep_cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      rep_cnt_q   <= '0;
      health_fail <= 1'b0;
    end else if (word_valid) begin
      prev_q      <= word;
      have_prev_q <= 1'b1;
      if (word_match) begin
        rep_cnt_q <= rep_next;
        if (rep_next >= RepW'(HT_CUTOFF - 1)) health_fail <= 1'b1;
      end else begin
        rep_cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/cr_kme_drng_key_assembler.sv
// Assembles pairs of 128-bit DRNG words into 256-bit keys behind a valid/ack handshake.
// Optional repetition-count health test enabled by defining CR_KME_DRNG_HEALTH_EN.
module cr_kme_drng_key_assembler
  import cr_kme_drng_pkg::*;
#(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned HT_CUTOFF = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   drng_valid,
  input  logic [DRNG_WORD_W-1:0] drng_256_out,
  input  logic                   seed_expired,
  output logic                   drng_ack,
  output logic                   drng_start,
  output logic                   key_valid,
  output logic [KEY_W-1:0]       key_out,
  input  logic                   key_ack,
  output logic [CNT_W-1:0]       key_cnt,
  output logic                   health_fail
);

  state_e state;
  logic   fetching;
  logic   word_match;
  logic   fail;

`ifdef CR_KME_DRNG_HEALTH_EN
  cr_kme_drng_rct #(
    .HT_CUTOFF (HT_CUTOFF)
  ) u_rct (
    .clk         (clk),
    .rst_n       (rst_n),
    .word_valid  (drng_ack),
    .word        (drng_256_out),
    .word_match  (word_match),
    .health_fail (fail)
  );
`else
  logic unused_ht_cutoff;
  assign unused_ht_cutoff = ^HT_CUTOFF;
  assign word_match       = 1'b0;
  assign fail             = 1'b0;
`endif

  assign health_fail = fail;
  assign fetching    = (state == FETCH_HI) || (state == FETCH_LO);
  // Gated by rst_n so the FIFO is never popped while reset is held.
  assign drng_ack    = drng_valid & fetching & ~fail & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH_HI;
      drng_start <= 1'b0;
      key_valid  <= 1'b0;
      key_out    <= '0;
      key_cnt    <= '0;
    end else begin
      drng_start <= seed_expired & (state != HOLD) & ~drng_start;
      if (!fail) begin
        unique case (state)
          FETCH_HI: begin
            if (drng_ack && !word_match) begin
              key_out[KEY_W-1:DRNG_WORD_W] <= drng_256_out;
              state                        <= FETCH_LO;
            end
          end
          FETCH_LO: begin
            if (drng_ack && !word_match) begin
              key_out[DRNG_WORD_W-1:0] <= drng_256_out;
              key_valid                <= 1'b1;
              state                    <= HOLD;
            end
          end
          HOLD: begin
            if (key_ack) begin
              key_valid <= 1'b0;
              if (key_cnt != '1) key_cnt <= key_cnt + 1'b1;
              state <= FETCH_HI;
            end
          end
          default: begin
            key_valid <= 1'b0;
            state     <= FETCH_HI;
          end
        endcase
      end
    end
  end

endmodule
